openram_scan_sequencer: RTL

// - Autonomous GPIO-mode driver for the OpenRAM testchip scan register; replaces bit-banging from the management core.
// - Accepts one parallel command word (chip select, port0 and port1 fields) and serially shifts it in.
// - Waits for the SRAM access, pulses the capture strobe, then shifts the captured word back out.
// - Returns the captured word on a valid/ready response interface.
// - Runs on the same clock that feeds the testchip gpio_clk; testchip in_select=1.

---
 rtl/openram_scan_sequencer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/openram_scan_sequencer.sv
// Serial scan sequencer for the OpenRAM testchip: shifts a command in, strobes the SRAM access, shifts the result out.
// Optional macro OPENRAM_SEQ_WRITE_ONLY_EN adds cmd_wo, which skips the capture/read-back phases.
module openram_scan_sequencer #(
    parameter int TOTAL_SIZE    = 112,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [TOTAL_SIZE-1:0] cmd_data,
`ifdef OPENRAM_SEQ_WRITE_ONLY_EN
    input  logic                  cmd_wo,
`endif
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [TOTAL_SIZE-1:0] rsp_data,
    output logic                  scan_en,
    output logic                  scan_out,
    output logic                  sram_load,
    input  logic                  scan_in,
    output logic                  busy
);

    localparam int CNT_MAX = (TOTAL_SIZE > SETTLE_CYCLES) ? TOTAL_SIZE : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SHIFT_LAST  = CNT_W'(TOTAL_SIZE - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SHIFT_IN, ST_SETTLE, ST_CAPTURE, ST_SHIFT_OUT, ST_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [TOTAL_SIZE-1:0] shadow_q, shadow_d;
    logic [TOTAL_SIZE-1:0] rsp_data_q, rsp_data_d;
    logic                  wo_q, wo_d;
    logic                  wo_in_s;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  scan_en_q, scan_en_d;
    logic                  scan_out_q, scan_out_d;
    logic                  sram_load_q, sram_load_d;
    logic                  busy_q, busy_d;
    state_e                after_settle_s;
    state_e                after_shift_in_s;

`ifdef OPENRAM_SEQ_WRITE_ONLY_EN
    assign wo_in_s = cmd_wo;
`else
    assign wo_in_s = 1'b0;
`endif

    // Write-only commands bypass capture and read-back; a zero settle time skips SETTLE.
    always_comb begin
        after_settle_s = wo_q ? ST_DONE : ST_CAPTURE;
        if (SETTLE_CYCLES == 0) begin
            after_shift_in_s = after_settle_s;
        end else begin
            after_shift_in_s = ST_SETTLE;
        end
    end

    // Next-state, counter, shadow shift register and response assembly.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        shadow_d   = shadow_q;
        rsp_data_d = rsp_data_q;
        wo_d       = wo_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (cmd_valid) begin
                    state_d    = ST_SHIFT_IN;
                    shadow_d   = cmd_data;
                    wo_d       = wo_in_s;
                    rsp_data_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT_IN: begin
                // The shadow copy shifts left so its MSB is always the next bit to drive.
                shadow_d = {shadow_q[TOTAL_SIZE-2:0], 1'b0};
                if (cnt_q == SHIFT_LAST) begin
                    state_d = after_shift_in_s;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_SHIFT_IN;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = after_settle_s;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_CAPTURE: begin
                state_d = ST_SHIFT_OUT;
                cnt_d   = '0;
            end
            ST_SHIFT_OUT: begin
                rsp_data_d = {rsp_data_q[TOTAL_SIZE-2:0], scan_in};
                if (cnt_q == SHIFT_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_SHIFT_OUT;
                end
            end
            ST_DONE: begin
                cnt_d = '0;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up with the state.
    always_comb begin
        cmd_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        scan_en_d   = 1'b0;
        scan_out_d  = 1'b0;
        sram_load_d = 1'b0;
        busy_d      = (state_d != ST_IDLE);
        case (state_d)
            ST_IDLE:      cmd_ready_d = 1'b1;
            ST_SHIFT_IN: begin
                scan_en_d  = 1'b1;
                scan_out_d = shadow_d[TOTAL_SIZE-1];
            end
            ST_SETTLE:    sram_load_d = 1'b0;
            ST_CAPTURE:   sram_load_d = 1'b1;
            ST_SHIFT_OUT: begin
                // Refill with ones leaves every SRAM deselected and write-disabled.
                scan_en_d  = 1'b1;
                scan_out_d = 1'b1;
            end
            ST_DONE:      rsp_valid_d = 1'b1;
            default:      cmd_ready_d = 1'b0;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shadow_q    <= '0;
            rsp_data_q  <= '0;
            wo_q        <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            scan_en_q   <= 1'b0;
            scan_out_q  <= 1'b0;
            sram_load_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            rsp_data_q  <= rsp_data_d;
            wo_q        <= wo_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            scan_en_q   <= scan_en_d;
            scan_out_q  <= scan_out_d;
            sram_load_q <= sram_load_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign scan_en   = scan_en_q;
    assign scan_out  = scan_out_q;
    assign sram_load = sram_load_q;
    assign busy      = busy_q;

endmodule
